// File: rtl/can_tx_mb_sched.sv
// Arbitrates NUM_MB transmit mailboxes onto one CAN tx path (lowest ID wins); request 3 cycles after pending.
// Holds tx_req until done/arb-loss; retries, cancels on abort/timeout/bus-off, no preemption of the active frame.
module can_tx_mb_sched #(
  parameter int NUM_MB  = 4,
  parameter int RETRY_W = 8,
  parameter int TO_W    = 16
) (
  input  logic                 clk_apb,
  input  logic                 rst_apb_n,
  input  logic [NUM_MB-1:0]    mb_valid,
  input  logic [32*NUM_MB-1:0] mb_id,
  input  logic [64*NUM_MB-1:0] mb_data,
  input  logic [RETRY_W-1:0]   retry_limit,
  input  logic [TO_W-1:0]      timeout_cycles,
  output logic [31:0]          tx_id,
  output logic [63:0]          tx_data,
  output logic                 tx_req,
  output logic                 tx_cancel,
  input  logic                 tx_done,
  input  logic                 tx_empty,
  input  logic                 arb_lost,
  input  logic                 bus_off,
  output logic [NUM_MB-1:0]    mb_done,
  output logic [NUM_MB-1:0]    mb_fail,
  output logic [1:0]           fail_code,
  output logic [2:0]           active_idx,
  output logic                 busy
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_REQ, S_WAIT, S_CANCEL} state_t;

  localparam logic [1:0] FC_RETRY   = 2'd0;
  localparam logic [1:0] FC_ABORT   = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;
  localparam logic [1:0] FC_BUSOFF  = 2'd3;

  state_t             state;
  logic [2:0]         win_idx;
  logic [1:0]         cancel_code;
  logic [TO_W-1:0]    to_cnt;
  logic [RETRY_W-1:0] retry_cnt [8];

  // Mailbox views padded to 8 entries so a 3-bit index never runs off the end.
  logic [31:0]        id_arr   [8];
  logic [63:0]        data_arr [8];
  logic [7:0]         valid8;
  logic [NUM_MB-1:0]  act_oh;
  logic [2:0]         win_sel;
  logic [28:0]        win_key;
  logic               win_found;
  logic [RETRY_W-1:0] ret_inc;

  always_comb begin
    valid8 = '0;
    act_oh = '0;
    for (int i = 0; i < 8; i++) begin
      id_arr[i]   = '0;
      data_arr[i] = '0;
    end
    for (int i = 0; i < NUM_MB; i++) begin
      id_arr[i]   = mb_id[32*i +: 32];
      data_arr[i] = mb_data[64*i +: 64];
      valid8[i]   = mb_valid[i];
      act_oh[i]   = (active_idx == 3'(i));
    end
  end

  // Strict less-than keeps ties with the lower index.
  always_comb begin
    win_found = 1'b0;
    win_sel   = '0;
    win_key   = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (mb_valid[i] && (!win_found || id_arr[i][28:0] < win_key)) begin
        win_found = 1'b1;
        win_key   = id_arr[i][28:0];
        win_sel   = 3'(i);
      end
    end
  end

  assign ret_inc = (retry_cnt[active_idx] == '1) ? retry_cnt[active_idx]
                                                 : retry_cnt[active_idx] + 1'b1;

  always_ff @(posedge clk_apb or negedge rst_apb_n) begin
    if (!rst_apb_n) begin
      state       <= S_IDLE;
      win_idx     <= '0;
      cancel_code <= '0;
      to_cnt      <= '0;
      for (int i = 0; i < 8; i++) retry_cnt[i] <= '0;
      tx_id       <= '0;
      tx_data     <= '0;
      tx_req      <= 1'b0;
      tx_cancel   <= 1'b0;
      mb_done     <= '0;
      mb_fail     <= '0;
      fail_code   <= '0;
      active_idx  <= '0;
      busy        <= 1'b0;
    end else begin
      mb_done <= '0;
      mb_fail <= '0;
      for (int i = 0; i < 8; i++) if (!valid8[i]) retry_cnt[i] <= '0;

      case (state)
        S_IDLE: begin
          if (|mb_valid && !bus_off) begin
            win_idx <= win_sel;
            state   <= S_SELECT;
            busy    <= 1'b1;
          end
        end
        S_SELECT: begin
          active_idx <= win_idx;
          tx_id      <= id_arr[win_idx];
          tx_data    <= data_arr[win_idx];
          state      <= S_REQ;
        end
        S_REQ: begin
          tx_req <= 1'b1;
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
          if (bus_off) begin
            tx_req                <= 1'b0;
            mb_fail               <= act_oh;
            fail_code             <= FC_BUSOFF;
            retry_cnt[active_idx] <= '0;
            state                 <= S_IDLE;
            busy                  <= 1'b0;
          end else if (tx_done) begin
            tx_req                <= 1'b0;
            mb_done               <= act_oh;
            retry_cnt[active_idx] <= '0;
            state                 <= S_IDLE;
            busy                  <= 1'b0;
          end else if (!valid8[active_idx]) begin
            tx_req      <= 1'b0;
            tx_cancel   <= 1'b1;
            cancel_code <= FC_ABORT;
            state       <= S_CANCEL;
          end else if (timeout_cycles != '0 && to_cnt == timeout_cycles) begin
            tx_req      <= 1'b0;
            tx_cancel   <= 1'b1;
            cancel_code <= FC_TIMEOUT;
            state       <= S_CANCEL;
          end else if (arb_lost) begin
            tx_req <= 1'b0;
            state  <= S_IDLE;
            busy   <= 1'b0;
            if (retry_limit != '0 && ret_inc == retry_limit) begin
              mb_fail               <= act_oh;
              fail_code             <= FC_RETRY;
              retry_cnt[active_idx] <= '0;
            end else begin
              retry_cnt[active_idx] <= ret_inc;
            end
          end
        end
        S_CANCEL: begin
          // A frame that completed despite the cancel counts as delivered.
          if (tx_done || tx_empty || bus_off) begin
            tx_cancel             <= 1'b0;
            retry_cnt[active_idx] <= '0;
            state                 <= S_IDLE;
            busy                  <= 1'b0;
            if (tx_done) begin
              mb_done <= act_oh;
            end else begin
              mb_fail   <= act_oh;
              fail_code <= tx_empty ? cancel_code : FC_BUSOFF;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
